// File: rtl/fir_cmd_sequencer.sv
// Command sequencer for the adaptive-coefficient FIR: decodes a byte-wide command
// stream into the FIR reset, gapless coefficient-load, sample-stream and flush sequences.
module fir_cmd_sequencer #(
  parameter int X_N_SIZE     = 8,
  parameter int NBR_OF_TAPS  = 2,
  parameter int SETUP_CYCLES = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [X_N_SIZE-1:0] cmd_data,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  output logic                fir_reset,
  output logic [X_N_SIZE-1:0] fir_x_n,
  output logic                fir_tvalid,
  output logic                fir_set_coeffs,
  output logic                busy,
  output logic                coeff_ok,
  output logic                err
);

  localparam int SETUP_W = $clog2(SETUP_CYCLES + 1);
  localparam int FLUSH_W = $clog2(2 * NBR_OF_TAPS);
  localparam int CNT_W0  = (SETUP_W > 7) ? SETUP_W : 7;
  localparam int CNT_W   = (FLUSH_W > CNT_W0) ? FLUSH_W : CNT_W0;

  localparam logic [CNT_W-1:0] SETUP_LAST = CNT_W'(SETUP_CYCLES);
  localparam logic [CNT_W-1:0] LOAD_LAST  = CNT_W'(NBR_OF_TAPS - 1);
  localparam logic [CNT_W-1:0] FLUSH_LAST = CNT_W'(2 * NBR_OF_TAPS - 2);

  localparam logic [1:0] OP_NOP    = 2'b00;
  localparam logic [1:0] OP_LOAD   = 2'b01;
  localparam logic [1:0] OP_STREAM = 2'b10;
  localparam logic [1:0] OP_FLUSH  = 2'b11;

  typedef enum logic [2:0] {
    S_INIT,
    S_IDLE,
    S_LOAD,
    S_LOAD_GAP,
    S_STREAM,
    S_FLUSH
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               broken_q, broken_d;

  logic               cmd_ready_q, cmd_ready_d;
  logic               fir_reset_q, fir_reset_d;
  logic [X_N_SIZE-1:0] fir_x_n_q, fir_x_n_d;
  logic               fir_tvalid_q, fir_tvalid_d;
  logic               fir_set_coeffs_q, fir_set_coeffs_d;
  logic               busy_q, busy_d;
  logic               coeff_ok_q, coeff_ok_d;
  logic               err_q, err_d;

  logic               xfer;
  logic [1:0]         opcode;
  logic [5:0]         len_field;

  assign xfer      = cmd_valid && cmd_ready_q;
  assign opcode    = cmd_data[X_N_SIZE-1 -: 2];
  assign len_field = cmd_data[5:0];

  // State register: the shared counter serves setup, load, stream and flush counting.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_INIT;
      cnt_q    <= '0;
      broken_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      broken_q <= broken_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    broken_d = broken_q;
    unique case (state_q)
      S_INIT: begin
        if (cnt_q == SETUP_LAST) state_d = S_IDLE;
        else                     cnt_d   = cnt_q + CNT_W'(1);
      end
      S_IDLE: begin
        if (xfer) begin
          unique case (opcode)
            OP_LOAD: begin
              state_d  = S_LOAD;
              cnt_d    = '0;
              broken_d = 1'b0;
            end
            OP_STREAM: begin
              state_d = S_STREAM;
              cnt_d   = CNT_W'(len_field) + CNT_W'(1);
            end
            OP_FLUSH: begin
              state_d = S_FLUSH;
              cnt_d   = FLUSH_LAST;
            end
            default: ;
          endcase
        end
      end
      S_LOAD: begin
        if (xfer) begin
          if (cnt_q == LOAD_LAST) state_d = S_LOAD_GAP;
          else                    cnt_d   = cnt_q + CNT_W'(1);
        end else begin
          broken_d = 1'b1;
        end
      end
      S_LOAD_GAP: state_d = S_IDLE;
      S_STREAM: begin
        if (xfer) begin
          cnt_d = cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) state_d = S_IDLE;
        end
      end
      S_FLUSH: begin
        if (cnt_q == '0) state_d = S_IDLE;
        else             cnt_d   = cnt_q - CNT_W'(1);
      end
      default: state_d = S_INIT;
    endcase
  end

  // Outputs are registered, so handshake and busy follow the state being entered.
  always_comb begin
    cmd_ready_d      = (state_d == S_IDLE) || (state_d == S_LOAD) || (state_d == S_STREAM);
    busy_d           = (state_d != S_IDLE);
    fir_reset_d      = 1'b0;
    fir_x_n_d        = fir_x_n_q;
    fir_tvalid_d     = 1'b0;
    fir_set_coeffs_d = 1'b0;
    coeff_ok_d       = coeff_ok_q;
    err_d            = err_q;
    unique case (state_q)
      S_IDLE: begin
        if (xfer && (opcode == OP_NOP) && cmd_data[0]) err_d = 1'b0;
      end
      S_LOAD: begin
        if (xfer) begin
          fir_x_n_d        = cmd_data;
          fir_set_coeffs_d = 1'b1;
        end else begin
          err_d = 1'b1;
        end
      end
      S_LOAD_GAP: coeff_ok_d = !broken_q;
      S_STREAM: begin
        if (xfer) begin
          fir_x_n_d    = cmd_data;
          fir_tvalid_d = 1'b1;
        end else begin
          err_d = 1'b1;
        end
      end
      default: ;
    endcase
    // Flush zeros start on the header edge itself and stop on the return to idle.
    if (state_d == S_FLUSH) begin
      fir_tvalid_d = 1'b1;
      fir_x_n_d    = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cmd_ready_q      <= 1'b0;
      fir_reset_q      <= 1'b1;
      fir_x_n_q        <= '0;
      fir_tvalid_q     <= 1'b0;
      fir_set_coeffs_q <= 1'b0;
      busy_q           <= 1'b1;
      coeff_ok_q       <= 1'b0;
      err_q            <= 1'b0;
    end else begin
      cmd_ready_q      <= cmd_ready_d;
      fir_reset_q      <= fir_reset_d;
      fir_x_n_q        <= fir_x_n_d;
      fir_tvalid_q     <= fir_tvalid_d;
      fir_set_coeffs_q <= fir_set_coeffs_d;
      busy_q           <= busy_d;
      coeff_ok_q       <= coeff_ok_d;
      err_q            <= err_d;
    end
  end

  assign cmd_ready      = cmd_ready_q;
  assign fir_reset      = fir_reset_q;
  assign fir_x_n        = fir_x_n_q;
  assign fir_tvalid     = fir_tvalid_q;
  assign fir_set_coeffs = fir_set_coeffs_q;
  assign busy           = busy_q;
  assign coeff_ok       = coeff_ok_q;
  assign err            = err_q;

endmodule

// File: tb/tb_fir_cmd_sequencer.sv
// Bench for fir_cmd_sequencer: directed and random command sequences, with a
// transaction-level model of the samples/coefficients the FIR should receive.
module tb_fir_cmd_sequencer;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] cmd_data;
  logic       cmd_valid;
  logic       cmd_ready, fir_reset, fir_tvalid, fir_set_coeffs, busy, coeff_ok, err;
  logic [7:0] fir_x_n;

  fir_cmd_sequencer #(.X_N_SIZE(8), .NBR_OF_TAPS(2), .SETUP_CYCLES(4)) dut (
    .clk(clk), .reset(reset), .cmd_data(cmd_data), .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready), .fir_reset(fir_reset), .fir_x_n(fir_x_n),
    .fir_tvalid(fir_tvalid), .fir_set_coeffs(fir_set_coeffs), .busy(busy),
    .coeff_ok(coeff_ok), .err(err)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  logic [7:0] exp_stream[$], exp_coef[$], got_stream[$], got_coef[$];
  bit         tv_tr[$], sc_tr[$], rd_tr[$];
  logic       exp_err, exp_cok;
  logic [7:0] last_x;

  // Observe what the FIR would sample, on the falling edge
  always @(negedge clk) begin
    tv_tr.push_back(fir_tvalid);
    sc_tr.push_back(fir_set_coeffs);
    rd_tr.push_back(cmd_ready);
    if (fir_tvalid === 1'b1)     got_stream.push_back(fir_x_n);
    if (fir_set_coeffs === 1'b1) got_coef.push_back(fir_x_n);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int ones(input bit q[$]);
    int n = 0;
    foreach (q[i]) if (q[i]) n++;
    return n;
  endfunction

  function automatic int span(input bit q[$]);
    int f = -1;
    int l = -1;
    foreach (q[i]) if (q[i]) begin
      if (f < 0) f = i;
      l = i;
    end
    return (f < 0) ? 0 : l - f + 1;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_logs();
    got_stream.delete(); got_coef.delete();
    tv_tr.delete(); sc_tr.delete(); rd_tr.delete();
    exp_stream.delete(); exp_coef.delete();
  endtask

  task automatic send(input logic [7:0] b);
    int k = 0;
    while (cmd_ready !== 1'b1 && k < 50) begin
      tick();
      k++;
    end
    if (cmd_ready !== 1'b1) check("ready_timeout", cmd_ready, 1);
    cmd_data  = b;
    cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic settle();
    int k = 0;
    while (busy !== 1'b0 && k < 300) begin
      tick();
      k++;
    end
    check("busy_idle", busy, 0);
    tick();
  endtask

  task automatic compare_q(input string tag, input logic [7:0] e[$], input logic [7:0] g[$]);
    check({tag, "_count"}, g.size(), e.size());
    for (int i = 0; i < e.size() && i < g.size(); i++)
      check($sformatf("%s_item%0d", tag, i), g[i], e[i]);
  endtask

  task automatic verify(input string tag);
    compare_q({tag, "_coef"}, exp_coef, got_coef);
    compare_q({tag, "_samp"}, exp_stream, got_stream);
    check({tag, "_err"}, err, exp_err);
    check({tag, "_coeff_ok"}, coeff_ok, exp_cok);
    check({tag, "_xn_hold"}, fir_x_n, last_x);
    clear_logs();
  endtask

  task automatic do_load(input logic [7:0] c0, input logic [7:0] c1, input bit bubble);
    send(8'h40);
    send(c0);
    if (bubble) tick();
    send(c1);
    exp_coef.push_back(c0);
    exp_coef.push_back(c1);
    if (bubble) exp_err = 1'b1;
    exp_cok = !bubble;
    last_x  = c1;
  endtask

  task automatic do_stream(input int len, input int bubble_mod);
    logic [7:0] b;
    send({2'b10, 6'(len - 1)});
    for (int i = 0; i < len; i++) begin
      b = 8'($urandom);
      exp_stream.push_back(b);
      send(b);
      last_x = b;
      if (bubble_mod > 0 && i < len - 1 && ($urandom % bubble_mod) == 0) begin
        tick();
        exp_err = 1'b1;
      end
    end
  endtask

  task automatic do_flush();
    send(8'hC0);
    for (int i = 0; i < 3; i++) exp_stream.push_back(8'h00);
    last_x = 8'h00;
  endtask

  task automatic do_nop(input logic [5:0] f);
    send({2'b00, f});
    if (f[0]) exp_err = 1'b0;
  endtask

  initial begin
    int n;
    reset = 1'b1; cmd_valid = 1'b0; cmd_data = 8'h00;
    exp_err = 1'b0; exp_cok = 1'b0; last_x = 8'h00;

    // Reset values
    repeat (3) tick();
    check("rst_ready", cmd_ready, 0);
    check("rst_fir_reset", fir_reset, 1);
    check("rst_busy", busy, 1);
    check("rst_tvalid", fir_tvalid, 0);
    check("rst_setc", fir_set_coeffs, 0);
    check("rst_xn", fir_x_n, 0);
    check("rst_coeff_ok", coeff_ok, 0);
    check("rst_err", err, 0);

    // Setup window after release
    reset = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      tick();
      check($sformatf("init_ready_%0d", i), cmd_ready, (i == 5));
      check($sformatf("init_fir_reset_%0d", i), fir_reset, 0);
    end
    check("init_busy", busy, 0);
    check("init_tvalid", fir_tvalid, 0);
    clear_logs();

    // Gapless coefficient load with gap-cycle timing
    send(8'h40); send(8'h05); send(8'h3A);
    exp_coef = '{8'h05, 8'h3A};
    check("gap_ready", cmd_ready, 0);
    check("gap_setc_last", fir_set_coeffs, 1);
    tick();
    check("post_gap_ready", cmd_ready, 1);
    check("post_gap_setc", fir_set_coeffs, 0);
    check("post_gap_cok", coeff_ok, 1);
    exp_cok = 1'b1; last_x = 8'h3A;
    settle();
    check("load_sc_ones", ones(sc_tr), 2);
    check("load_sc_span", span(sc_tr), 2);
    verify("load_ok");

    // Gapless 4-sample stream
    send(8'h83); send(8'h01); send(8'h02); send(8'h03); send(8'h04);
    exp_stream = '{8'h01, 8'h02, 8'h03, 8'h04};
    last_x = 8'h04;
    settle();
    check("strm_tv_ones", ones(tv_tr), 4);
    check("strm_tv_span", span(tv_tr), 4);
    verify("stream4");

    // Stream with a bubble, then error clear
    send(8'h81); send(8'hA5); tick(); send(8'h5A);
    exp_stream = '{8'hA5, 8'h5A};
    exp_err = 1'b1; last_x = 8'h5A;
    settle();
    check("bub_tv_ones", ones(tv_tr), 2);
    check("bub_tv_span", span(tv_tr), 3);
    verify("stream_bubble");
    do_nop(6'h01);
    settle();
    verify("nop_clear");

    // Load with a bubble breaks coeff_ok
    do_load(8'h11, 8'h22, 1'b1);
    settle();
    check("bload_sc_ones", ones(sc_tr), 2);
    check("bload_sc_span", span(sc_tr), 3);
    verify("load_bubble");
    do_nop(6'h01);
    settle();
    verify("nop_clear2");

    // Flush: three zero samples with cmd_ready low throughout
    do_flush();
    settle();
    check("flush_tv_ones", ones(tv_tr), 3);
    check("flush_tv_span", span(tv_tr), 3);
    n = 0;
    foreach (tv_tr[i]) if (tv_tr[i] && rd_tr[i]) n++;
    check("flush_ready_low", n, 0);
    verify("flush");

    // Randomized command mix
    for (int it = 0; it < 30; it++) begin
      case ($urandom_range(0, 3))
        0: do_load(8'($urandom), 8'($urandom), ($urandom % 3) == 0);
        1: do_stream($urandom_range(1, 64), 8);
        2: do_flush();
        default: do_nop(6'($urandom));
      endcase
      settle();
      verify($sformatf("rnd%0d", it));
    end

    // Reset during the second flush cycle
    send(8'hC0);
    tick();
    check("flush2_tvalid", fir_tvalid, 1);
    reset = 1'b1;
    tick();
    check("mid_rst_ready", cmd_ready, 0);
    check("mid_rst_fir_reset", fir_reset, 1);
    check("mid_rst_tvalid", fir_tvalid, 0);
    check("mid_rst_xn", fir_x_n, 0);
    check("mid_rst_busy", busy, 1);
    check("mid_rst_setc", fir_set_coeffs, 0);
    check("mid_rst_cok", coeff_ok, 0);
    check("mid_rst_err", err, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
